// File: rtl/blit_loop_count.sv
// ----------------------------------------------------------------------------
// blit_loop_count
//
// Blitter loop counter. Holds the inner (pixels-per-line) and outer (line)
// counts loaded by the GPU register decode and steps them under control of
// the blitter state machine. Reports end-of-line and end-of-blit as
// registered one-cycle pulses and presents the live counts for readback.
//
// A count value of zero stands for 2^CW iterations: the decrement wraps
// 0 -> all-ones, so a line loaded with 0 runs the full counter range.
//
// Ports:
//   sys_clk    in   1     system clock, rising edge
//   reset      in   1     synchronous active-high reset
//   countld    in   1     load strobe: gpu_din -> {ocount, icount}, iinit
//   cmdld      in   1     command write strobe, arms the counter
//   stopld     in   1     abort strobe, disarms with counts frozen
//   gpu_din    in   2*CW  {outer count, inner count}
//   step       in   1     one pixel/phrase completed
//   active     out  1     counter armed, blit in progress
//   inner_end  out  1     pulse: a line finished, more lines remain
//   blit_done  out  1     pulse: final step of the final line
//   count_out  out  2*CW  {ocount, icount}
// ----------------------------------------------------------------------------
module blit_loop_count #(
    parameter int CW = 16
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            countld,
    input  logic            cmdld,
    input  logic            stopld,
    input  logic [2*CW-1:0] gpu_din,
    input  logic            step,
    output logic            active,
    output logic            inner_end,
    output logic            blit_done,
    output logic [2*CW-1:0] count_out
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] icount_r;
    logic [CW-1:0] ocount_r;
    logic [CW-1:0] iinit_r;
    logic          active_r;
    logic          inner_end_r;
    logic          blit_done_r;

    logic [CW-1:0] icount_s;
    logic [CW-1:0] ocount_s;
    logic [CW-1:0] iinit_s;
    logic          active_s;
    logic          inner_end_s;
    logic          blit_done_s;
    logic          step_ok_s;
    logic          line_last_s;
    logic          blit_last_s;

    // Next-state decode: load beats step, abort beats arm and step.
    always_comb begin
        icount_s    = icount_r;
        ocount_s    = ocount_r;
        iinit_s     = iinit_r;
        active_s    = active_r;
        inner_end_s = 1'b0;
        blit_done_s = 1'b0;

        // A step only counts while armed and when no load or abort claims the cycle.
        step_ok_s   = step & active_r & ~countld & ~stopld;
        line_last_s = (icount_r == CNT_ONE);
        blit_last_s = line_last_s & (ocount_r == CNT_ONE);

        if (countld) begin
            icount_s = gpu_din[CW-1:0];
            iinit_s  = gpu_din[CW-1:0];
            ocount_s = gpu_din[2*CW-1:CW];
        end else if (step_ok_s) begin
            if (!line_last_s) begin
                icount_s = icount_r - CNT_ONE;
            end else if (!blit_last_s) begin
                // Reload the line so the very next step decrements from iinit.
                icount_s    = iinit_r;
                ocount_s    = ocount_r - CNT_ONE;
                inner_end_s = 1'b1;
            end else begin
                icount_s    = CNT_ZERO;
                ocount_s    = CNT_ZERO;
                blit_done_s = 1'b1;
            end
        end else begin
            icount_s = icount_r;
            ocount_s = ocount_r;
        end

        // The final step's clear wins over a coincident arm.
        if (stopld) begin
            active_s = 1'b0;
        end else if (blit_done_s) begin
            active_s = 1'b0;
        end else if (cmdld) begin
            active_s = 1'b1;
        end else begin
            active_s = active_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            icount_r    <= CNT_ZERO;
            ocount_r    <= CNT_ZERO;
            iinit_r     <= CNT_ZERO;
            active_r    <= 1'b0;
            inner_end_r <= 1'b0;
            blit_done_r <= 1'b0;
        end else begin
            icount_r    <= icount_s;
            ocount_r    <= ocount_s;
            iinit_r     <= iinit_s;
            active_r    <= active_s;
            inner_end_r <= inner_end_s;
            blit_done_r <= blit_done_s;
        end
    end

    assign active    = active_r;
    assign inner_end = inner_end_r;
    assign blit_done = blit_done_r;
    assign count_out = {ocount_r, icount_r};

endmodule

// File: tb/tb_blit_loop_count.sv
// ----------------------------------------------------------------------------
// tb_blit_loop_count
//
// Self-checking bench for blit_loop_count (CW=16). A table of directed
// vectors with hand-computed expectations covers the listed scenarios, a
// hand-written loop covers the zero-means-2^CW case, and a randomized run
// is compared against a reference model that keeps the counts as true
// iteration numbers (1..2^CW) rather than as wrapped register values.
// ----------------------------------------------------------------------------
module tb_blit_loop_count;

    localparam int CW   = 16;
    localparam int FULL = 65536;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        countld = 1'b0;
    logic        cmdld   = 1'b0;
    logic        stopld  = 1'b0;
    logic        step    = 1'b0;
    logic [31:0] gpu_din = 32'h0000_0000;
    logic        active;
    logic        inner_end;
    logic        blit_done;
    logic [31:0] count_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: iteration counts, 0 in a register means FULL here.
    int m_i    = FULL;
    int m_o    = FULL;
    int m_init = FULL;
    bit m_act  = 1'b0;
    bit m_ie   = 1'b0;
    bit m_bd   = 1'b0;

    blit_loop_count #(.CW(CW)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .countld   (countld),
        .cmdld     (cmdld),
        .stopld    (stopld),
        .gpu_din   (gpu_din),
        .step      (step),
        .active    (active),
        .inner_end (inner_end),
        .blit_done (blit_done),
        .count_out (count_out)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          r;
        bit          cl;
        bit          cm;
        bit          sp;
        bit          st;
        logic [31:0] din;
        logic [31:0] e_cnt;
        bit          e_act;
        bit          e_ie;
        bit          e_bd;
    } vec_t;

    vec_t vecs[$];

    function automatic int eff(input logic [15:0] v);
        return (v == 16'h0000) ? FULL : int'(v);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, got, exp);
        end
    endtask

    // Advance the reference model by one clock with the given inputs.
    task automatic model_update(input bit r, input bit cl, input bit cm,
                                input bit sp, input bit st, input logic [31:0] d);
        bit accept;
        m_ie = 1'b0;
        m_bd = 1'b0;
        if (r) begin
            m_i = FULL; m_o = FULL; m_init = FULL; m_act = 1'b0;
        end else begin
            accept = st && m_act && !cl && !sp;
            if (cl) begin
                m_i    = eff(d[15:0]);
                m_init = m_i;
                m_o    = eff(d[31:16]);
            end else if (accept) begin
                if (m_i > 1) begin
                    m_i = m_i - 1;
                end else if (m_o > 1) begin
                    m_o  = m_o - 1;
                    m_i  = m_init;
                    m_ie = 1'b1;
                end else begin
                    m_i = FULL; m_o = FULL;
                    m_bd = 1'b1;
                end
            end
            if (sp || m_bd) m_act = 1'b0;
            else if (cm)    m_act = 1'b1;
        end
    endtask

    task automatic cycle(input bit r, input bit cl, input bit cm,
                         input bit sp, input bit st, input logic [31:0] d);
        reset = r; countld = cl; cmdld = cm; stopld = sp; step = st; gpu_din = d;
        model_update(r, cl, cm, sp, st, d);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_check(input string tag);
        logic [31:0] ic;
        logic [31:0] oc;
        ic = m_i % FULL;
        oc = m_o % FULL;
        check({tag, " count_out"}, count_out, {oc[15:0], ic[15:0]});
        check({tag, " active"},    {31'd0, active},    {31'd0, m_act});
        check({tag, " inner_end"}, {31'd0, inner_end}, {31'd0, m_ie});
        check({tag, " blit_done"}, {31'd0, blit_done}, {31'd0, m_bd});
    endtask

    function automatic vec_t v(input bit r, input bit cl, input bit cm, input bit sp,
                               input bit st, input logic [31:0] d, input logic [31:0] ec,
                               input bit ea, input bit ei, input bit eb);
        vec_t x;
        x.r = r; x.cl = cl; x.cm = cm; x.sp = sp; x.st = st; x.din = d;
        x.e_cnt = ec; x.e_act = ea; x.e_ie = ei; x.e_bd = eb;
        return x;
    endfunction

    initial begin
        int ie_seen;
        int bd_at;
        int ocnt;

        // Reset then load while idle; step while idle is ignored.
        vecs.push_back(v(1,0,0,0,0, 32'h0000_0000, 32'h0000_0000, 0,0,0));
        vecs.push_back(v(0,0,0,0,0, 32'h0000_0000, 32'h0000_0000, 0,0,0));
        vecs.push_back(v(0,1,0,0,0, 32'h0003_0004, 32'h0003_0004, 0,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0000_0000, 32'h0003_0004, 0,0,0));
        vecs.push_back(v(0,0,1,0,0, 32'h0000_0000, 32'h0003_0004, 1,0,0));
        // Full run: inner 4, outer 3, steps back to back.
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0003_0003, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0003_0002, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0003_0001, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0002_0004, 1,1,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0002_0003, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0002_0002, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0002_0001, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0001_0004, 1,1,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0001_0003, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0001_0002, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0001_0001, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0000_0000, 0,0,1));
        vecs.push_back(v(0,0,0,0,1, 32'h0, 32'h0000_0000, 0,0,0));
        // Abort with a coincident step.
        vecs.push_back(v(0,1,0,0,0, 32'h0002_0005, 32'h0002_0005, 0,0,0));
        vecs.push_back(v(0,0,1,0,0, 32'h0,         32'h0002_0005, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0,         32'h0002_0004, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0,         32'h0002_0003, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0,         32'h0002_0002, 1,0,0));
        vecs.push_back(v(0,0,0,1,1, 32'h0,         32'h0002_0002, 0,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0,         32'h0002_0002, 0,0,0));
        // Load colliding with a step mid-blit, then arm together with a step.
        vecs.push_back(v(0,1,0,0,0, 32'h0002_0004, 32'h0002_0004, 0,0,0));
        vecs.push_back(v(0,0,1,0,0, 32'h0,         32'h0002_0004, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0,         32'h0002_0003, 1,0,0));
        vecs.push_back(v(0,1,0,0,1, 32'h0005_0007, 32'h0005_0007, 1,0,0));
        vecs.push_back(v(0,0,0,0,1, 32'h0,         32'h0005_0006, 1,0,0));
        vecs.push_back(v(0,0,1,0,1, 32'h0,         32'h0005_0005, 1,0,0));
        // Reset together with the final step.
        vecs.push_back(v(0,1,0,0,0, 32'h0001_0001, 32'h0001_0001, 1,0,0));
        vecs.push_back(v(0,0,1,0,0, 32'h0,         32'h0001_0001, 1,0,0));
        vecs.push_back(v(1,0,0,0,1, 32'h0,         32'h0000_0000, 0,0,0));
        vecs.push_back(v(0,0,0,0,0, 32'h0,         32'h0000_0000, 0,0,0));
        // Final step together with arm: the clear wins; abort beats arm.
        vecs.push_back(v(0,1,0,0,0, 32'h0001_0001, 32'h0001_0001, 0,0,0));
        vecs.push_back(v(0,0,1,0,0, 32'h0,         32'h0001_0001, 1,0,0));
        vecs.push_back(v(0,0,1,0,1, 32'h0,         32'h0000_0000, 0,0,1));
        vecs.push_back(v(0,0,0,0,0, 32'h0,         32'h0000_0000, 0,0,0));
        vecs.push_back(v(0,0,1,1,0, 32'h0,         32'h0000_0000, 0,0,0));

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].cl, vecs[i].cm, vecs[i].sp, vecs[i].st, vecs[i].din);
            check($sformatf("vec%0d count_out", i), count_out, vecs[i].e_cnt);
            check($sformatf("vec%0d active", i),    {31'd0, active},    {31'd0, vecs[i].e_act});
            check($sformatf("vec%0d inner_end", i), {31'd0, inner_end}, {31'd0, vecs[i].e_ie});
            check($sformatf("vec%0d blit_done", i), {31'd0, blit_done}, {31'd0, vecs[i].e_bd});
        end

        // Zero inner count with one line: 65536 steps, no line-end pulses.
        cycle(1,0,0,0,0, 32'h0);
        cycle(0,1,0,0,0, 32'h0001_0000);
        cycle(0,0,1,0,0, 32'h0);
        model_check("zmax armed");
        ie_seen = 0;
        bd_at   = -1;
        for (int k = 1; k <= FULL; k++) begin
            cycle(0,0,0,0,1, 32'h0);
            model_check("zmax");
            if (k == 1) check("zmax icount after step1", {16'h0000, count_out[15:0]}, 32'h0000_FFFF);
            if (inner_end) ie_seen++;
            if (blit_done && bd_at < 0) bd_at = k;
        end
        check("zmax inner_end pulses", ie_seen, 32'd0);
        check("zmax blit_done step", bd_at, 32'd65536);

        // Randomized traffic against the reference model.
        cycle(1,0,0,0,0, 32'h0);
        model_check("rand reset");
        for (int k = 0; k < 4000; k++) begin
            bit r, cl, cm, sp, st;
            logic [31:0] d;
            r  = ($urandom_range(0, 199) == 0);
            cl = ($urandom_range(0, 19) == 0);
            cm = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 9) < 7);
            ocnt = $urandom_range(0, 30);
            d[31:16] = (ocnt == 0) ? 16'h0000 : 16'(ocnt % 4 + 1);
            d[15:0]  = ($urandom_range(0, 49) == 0) ? 16'h0000 : 16'($urandom_range(1, 5));
            cycle(r, cl, cm, sp, st, d);
            model_check("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
